scr1_ahb_arb2: RTL and testbench

Two-master to one-slave AHB-Lite arbiter. It lets the instruction-memory bridge and the data-memory bridge share a single AHB port, for example the unified external memory port on Tang Primer 20K.
- Each master's address phase is captured into a holding register, arbitrated, and then replayed to the slave.
- The master's data phase is stalled until its replayed transfer completes.
- Single transfers only; no bursts and no locked transfers.

---
 rtl/scr1_ahb_arb2_if.sv | 26 ++
 rtl/scr1_ahb_arb2.sv | 148 ++++++++++++++
 tb/tb_scr1_ahb_arb2.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_ahb_arb2_if.sv
// rtl/scr1_ahb_arb2_if.sv - AHB-Lite single-port signal bundle
interface scr1_ahb_arb2_if #(
  parameter int AHB_W = 32
);
  logic [1:0]       htrans;
  logic [AHB_W-1:0] haddr;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [3:0]       hprot;
  logic [2:0]       hburst;
  logic             hmastlock;
  logic [AHB_W-1:0] hwdata;
  logic             hready;
  logic [AHB_W-1:0] hrdata;
  logic             hresp;

  modport master (
    output htrans, haddr, hwrite, hsize, hprot, hburst, hmastlock, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  htrans, haddr, hwrite, hsize, hprot, hwdata,
    output hready, hrdata, hresp
  );
endinterface

// File: rtl/scr1_ahb_arb2.sv
// rtl/scr1_ahb_arb2.sv - two-master AHB-Lite arbiter with held and replayed address phases
module scr1_ahb_arb2 #(
  parameter int AHB_W      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  scr1_ahb_arb2_if.slave   m0,
  scr1_ahb_arb2_if.slave   m1,
  scr1_ahb_arb2_if.master  s
);
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PEND       = 2'd1;
  localparam logic [1:0] ST_DATA       = 2'd2;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  logic [1:0]       req;
  logic [AHB_W-1:0] in_addr  [2];
  logic             in_write [2];
  logic [2:0]       in_size  [2];
  logic [3:0]       in_prot  [2];
  logic [AHB_W-1:0] in_wdata [2];

  assign req         = {m1.htrans[1], m0.htrans[1]};
  assign in_addr[0]  = m0.haddr;
  assign in_addr[1]  = m1.haddr;
  assign in_write[0] = m0.hwrite;
  assign in_write[1] = m1.hwrite;
  assign in_size[0]  = m0.hsize;
  assign in_size[1]  = m1.hsize;
  assign in_prot[0]  = m0.hprot;
  assign in_prot[1]  = m1.hprot;
  assign in_wdata[0] = m0.hwdata;
  assign in_wdata[1] = m1.hwdata;

  logic [1:0]       state  [2];
  logic [AHB_W-1:0] h_addr [2];
  logic             h_write[2];
  logic [2:0]       h_size [2];
  logic [3:0]       h_prot [2];

  logic [AHB_W-1:0] last_addr;
  logic             last_write;
  logic [2:0]       last_size;
  logic [3:0]       last_prot;

  logic [1:0] pend;
  logic [1:0] cap;
  logic       issue;
  logic       accept;
  logic       sel;
  logic       rr_next;
  logic       lock_vld;
  logic       lock_sel;
  logic       own_vld;
  logic       own_sel;

  assign pend   = {state[1] == ST_PEND, state[0] == ST_PEND};
  assign issue  = |pend;
  assign accept = issue & s.hready;

  always_comb begin
    cap = '0;
    for (int i = 0; i < 2; i++) begin
      cap[i] = req[i] & ((state[i] == ST_IDLE) | ((state[i] == ST_DATA) & s.hready));
    end
  end

  // A stalled issue keeps its master so the slave never sees the address change mid-wait.
  always_comb begin
    if (lock_vld) begin
      sel = lock_sel;
    end else if (&pend) begin
      sel = FIXED_PRIO ? 1'b0 : rr_next;
    end else begin
      sel = pend[1] & ~pend[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state[0]   <= ST_IDLE;
      state[1]   <= ST_IDLE;
      rr_next    <= 1'b0;
      lock_vld   <= 1'b0;
      lock_sel   <= 1'b0;
      own_vld    <= 1'b0;
      own_sel    <= 1'b0;
      last_addr  <= '0;
      last_write <= 1'b0;
      last_size  <= '0;
      last_prot  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          ST_IDLE: if (cap[i]) state[i] <= ST_PEND;
          ST_PEND: if (accept && (sel == 1'(i))) state[i] <= ST_DATA;
          ST_DATA: if (s.hready) state[i] <= cap[i] ? ST_PEND : ST_IDLE;
          default: state[i] <= ST_IDLE;
        endcase
      end
      if (accept) begin
        rr_next <= ~sel;
      end
      lock_vld <= issue & ~s.hready;
      lock_sel <= sel;
      if (s.hready) begin
        own_vld <= issue;
        own_sel <= sel;
      end
      if (issue) begin
        last_addr  <= h_addr[sel];
        last_write <= h_write[sel];
        last_size  <= h_size[sel];
        last_prot  <= h_prot[sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        h_addr[i]  <= in_addr[i];
        h_write[i] <= in_write[i];
        h_size[i]  <= in_size[i];
        h_prot[i]  <= in_prot[i];
      end
    end
  end

  assign s.htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s.haddr     = issue ? h_addr[sel]  : last_addr;
  assign s.hwrite    = issue ? h_write[sel] : last_write;
  assign s.hsize     = issue ? h_size[sel]  : last_size;
  assign s.hprot     = issue ? h_prot[sel]  : last_prot;
  assign s.hburst    = HBURST_SINGLE;
  assign s.hmastlock = 1'b0;
  assign s.hwdata    = own_vld ? in_wdata[own_sel] : '0;

  assign m0.hready = (state[0] == ST_DATA) ? s.hready : (state[0] != ST_PEND);
  assign m1.hready = (state[1] == ST_DATA) ? s.hready : (state[1] != ST_PEND);
  assign m0.hresp  = (state[0] == ST_DATA) & s.hresp;
  assign m1.hresp  = (state[1] == ST_DATA) & s.hresp;
  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;
endmodule

// File: tb/tb_scr1_ahb_arb2.sv
// tb/tb_scr1_ahb_arb2.sv - bench for scr1_ahb_arb2, round-robin and fixed-priority instances
module tb_scr1_ahb_arb2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // inputs per instance g (0 = round-robin, 1 = fixed priority) and master m
  logic [1:0]   d_htrans [2][2];
  logic [W-1:0] d_haddr  [2][2];
  logic         d_hwrite [2][2];
  logic [2:0]   d_hsize  [2][2];
  logic [3:0]   d_hprot  [2][2];
  logic [W-1:0] d_hwdata [2][2];
  logic         d_s_hready [2];
  logic         d_s_hresp  [2];
  logic [W-1:0] d_s_hrdata [2];

  logic         o_hready [2][2];
  logic         o_hresp  [2][2];
  logic [W-1:0] o_hrdata [2][2];
  logic [1:0]   o_htrans [2];
  logic [W-1:0] o_haddr  [2];
  logic         o_hwrite [2];
  logic [2:0]   o_hsize  [2];
  logic [3:0]   o_hprot  [2];
  logic [2:0]   o_hburst [2];
  logic         o_hmastlock [2];
  logic [W-1:0] o_hwdata [2];

  for (genvar g = 0; g < 2; g++) begin : gi
    scr1_ahb_arb2_if #(.AHB_W(W)) mi0 ();
    scr1_ahb_arb2_if #(.AHB_W(W)) mi1 ();
    scr1_ahb_arb2_if #(.AHB_W(W)) si ();

    assign mi0.htrans = d_htrans[g][0];
    assign mi0.haddr  = d_haddr[g][0];
    assign mi0.hwrite = d_hwrite[g][0];
    assign mi0.hsize  = d_hsize[g][0];
    assign mi0.hprot  = d_hprot[g][0];
    assign mi0.hwdata = d_hwdata[g][0];
    assign mi0.hburst = 3'b000;
    assign mi0.hmastlock = 1'b0;
    assign mi1.htrans = d_htrans[g][1];
    assign mi1.haddr  = d_haddr[g][1];
    assign mi1.hwrite = d_hwrite[g][1];
    assign mi1.hsize  = d_hsize[g][1];
    assign mi1.hprot  = d_hprot[g][1];
    assign mi1.hwdata = d_hwdata[g][1];
    assign mi1.hburst = 3'b000;
    assign mi1.hmastlock = 1'b0;
    assign si.hready  = d_s_hready[g];
    assign si.hresp   = d_s_hresp[g];
    assign si.hrdata  = d_s_hrdata[g];

    assign o_hready[g][0] = mi0.hready;
    assign o_hready[g][1] = mi1.hready;
    assign o_hresp[g][0]  = mi0.hresp;
    assign o_hresp[g][1]  = mi1.hresp;
    assign o_hrdata[g][0] = mi0.hrdata;
    assign o_hrdata[g][1] = mi1.hrdata;
    assign o_htrans[g]    = si.htrans;
    assign o_haddr[g]     = si.haddr;
    assign o_hwrite[g]    = si.hwrite;
    assign o_hsize[g]     = si.hsize;
    assign o_hprot[g]     = si.hprot;
    assign o_hburst[g]    = si.hburst;
    assign o_hmastlock[g] = si.hmastlock;
    assign o_hwdata[g]    = si.hwdata;

    scr1_ahb_arb2 #(.AHB_W(W), .FIXED_PRIO(g == 1)) dut (
      .clk (clk),
      .rst (rst),
      .m0  (mi0),
      .m1  (mi1),
      .s   (si)
    );
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: each master has a waiting request and/or an outstanding transfer.
  typedef struct packed {
    logic [W-1:0] addr;
    logic         wr;
    logic [2:0]   size;
    logic [3:0]   prot;
  } req_t;

  bit   waiting [2][2];
  bit   outst   [2][2];
  req_t held    [2][2];
  req_t last_r  [2];
  int   owner   [2];
  int   favour  [2];
  int   locked  [2];
  bit   model_on = 1'b0;

  always @(negedge clk) begin
    bit   anyp;
    bit   acc;
    bit   rdy;
    bit   free_m [2];
    int   pick;
    req_t cur;
    for (int g = 0; g < 2; g++) begin
      anyp = waiting[g][0] | waiting[g][1];
      rdy  = d_s_hready[g];
      if (locked[g] >= 0)                   pick = locked[g];
      else if (waiting[g][0] && waiting[g][1]) pick = (g == 1) ? 0 : favour[g];
      else                                  pick = waiting[g][0] ? 0 : 1;
      cur = anyp ? held[g][pick] : last_r[g];
      if (model_on) begin
        chk($sformatf("g%0d s_htrans", g), o_htrans[g], anyp ? 2 : 0);
        chk($sformatf("g%0d s_haddr", g), o_haddr[g], cur.addr);
        chk($sformatf("g%0d s_hwrite", g), o_hwrite[g], cur.wr);
        chk($sformatf("g%0d s_hsize", g), o_hsize[g], cur.size);
        chk($sformatf("g%0d s_hprot", g), o_hprot[g], cur.prot);
        chk($sformatf("g%0d s_hburst", g), o_hburst[g], 0);
        chk($sformatf("g%0d s_hmastlock", g), o_hmastlock[g], 0);
        chk($sformatf("g%0d s_hwdata", g), o_hwdata[g], (owner[g] >= 0) ? d_hwdata[g][owner[g]] : 0);
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("g%0d m%0d_hready", g, m), o_hready[g][m],
              waiting[g][m] ? 0 : (outst[g][m] ? rdy : 1));
          chk($sformatf("g%0d m%0d_hresp", g, m), o_hresp[g][m], outst[g][m] ? d_s_hresp[g] : 0);
          chk($sformatf("g%0d m%0d_hrdata", g, m), o_hrdata[g][m], d_s_hrdata[g]);
        end
      end
      if (rst) begin
        for (int m = 0; m < 2; m++) begin
          waiting[g][m] = 1'b0;
          outst[g][m]   = 1'b0;
        end
        last_r[g] = '0;
        owner[g]  = -1;
        favour[g] = 0;
        locked[g] = -1;
      end else if (model_on) begin
        acc = anyp && rdy;
        for (int m = 0; m < 2; m++) free_m[m] = !waiting[g][m] && (!outst[g][m] || rdy);
        for (int m = 0; m < 2; m++) begin
          if (outst[g][m] && rdy) outst[g][m] = 1'b0;
          if (acc && pick == m) begin
            waiting[g][m] = 1'b0;
            outst[g][m]   = 1'b1;
          end
          if (free_m[m] && d_htrans[g][m][1]) begin
            waiting[g][m]   = 1'b1;
            held[g][m].addr = d_haddr[g][m];
            held[g][m].wr   = d_hwrite[g][m];
            held[g][m].size = d_hsize[g][m];
            held[g][m].prot = d_hprot[g][m];
          end
        end
        if (rdy) owner[g] = acc ? pick : -1;
        if (acc) favour[g] = 1 - pick;
        locked[g] = (anyp && !rdy) ? pick : -1;
        if (anyp) last_r[g] = cur;
      end
    end
    if (rst) model_on = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic [1:0] tr, input logic [W-1:0] addr, input logic wr);
    for (int g = 0; g < 2; g++) begin
      d_htrans[g][m] = tr;
      d_haddr[g][m]  = addr;
      d_hwrite[g][m] = wr;
    end
  endtask

  task automatic set_wdata(input int m, input logic [W-1:0] v);
    for (int g = 0; g < 2; g++) d_hwdata[g][m] = v;
  endtask

  task automatic set_s(input logic rdy, input logic resp, input logic [W-1:0] rdata);
    for (int g = 0; g < 2; g++) begin
      d_s_hready[g] = rdy;
      d_s_hresp[g]  = resp;
      d_s_hrdata[g] = rdata;
    end
  endtask

  bit  smp_rdy [2][2];
  bit  smp_ns  [2];
  bit  dp      [2];
  bit  err_2nd [2];
  bit  was_rst;
  int  r;
  int  req_pct;

  initial begin
    for (int g = 0; g < 2; g++) begin
      for (int m = 0; m < 2; m++) begin
        d_hsize[g][m]  = 3'd2;
        d_hprot[g][m]  = 4'h3;
        d_hwdata[g][m] = '0;
      end
    end
    set_m(0, 2'b10, 32'h111, 1'b1);
    set_m(1, 2'b10, 32'h222, 1'b0);
    set_s(1'b1, 1'b0, 32'h0);

    // reset held across two edges while both masters request
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset m0_hready", o_hready[0][0], 1);
    chk("reset m1_hready", o_hready[0][1], 1);
    chk("reset s_htrans", o_htrans[0], 0);
    chk("reset m0_hresp", o_hresp[0][0], 0);

    // single imem read
    step();
    rst = 1'b0;
    set_m(0, 2'b00, 32'h0, 1'b0);
    set_m(1, 2'b10, 32'h200, 1'b0);
    step();
    set_m(1, 2'b00, 32'h0, 1'b0);
    @(negedge clk);
    chk("imem s_htrans", o_htrans[0], 2);
    chk("imem s_haddr", o_haddr[0], 32'h200);
    step();
    set_s(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("imem m1_hready", o_hready[0][1], 1);
    chk("imem m1_hrdata", o_hrdata[0][1], 32'hDEADBEEF);
    chk("imem m0_hready", o_hready[0][0], 1);
    step();

    // contention: m0 write vs m1 read
    set_m(0, 2'b10, 32'h1000, 1'b1);
    set_m(1, 2'b10, 32'h200, 1'b0);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0);
    set_m(1, 2'b00, 32'h0, 1'b0);
    set_wdata(0, 32'h55AA55AA);
    @(negedge clk);
    chk("cont first s_haddr", o_haddr[0], 32'h1000);
    chk("cont first s_hwrite", o_hwrite[0], 1);
    chk("cont m1_hready stalled", o_hready[0][1], 0);
    step();
    @(negedge clk);
    chk("cont second s_haddr", o_haddr[0], 32'h200);
    chk("cont s_hwdata", o_hwdata[0], 32'h55AA55AA);
    chk("cont m0_hready", o_hready[0][0], 1);
    step();
    step();

    // m0 alone, then contention: round-robin favours m1, fixed priority keeps m0
    set_m(0, 2'b10, 32'h3000, 1'b0);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0);
    step();
    set_m(0, 2'b10, 32'h3004, 1'b0);
    set_m(1, 2'b10, 32'h300, 1'b0);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0);
    set_m(1, 2'b00, 32'h0, 1'b0);
    @(negedge clk);
    chk("rr grant after m0", o_haddr[0], 32'h300);
    chk("fixed grant m0", o_haddr[1], 32'h3004);
    step();
    step();
    step();

    // slave wait states on an m0 write while m1 waits
    set_m(0, 2'b10, 32'h4000, 1'b1);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0);
    set_wdata(0, 32'h44444444);
    set_m(1, 2'b10, 32'h400, 1'b0);
    step();
    set_m(1, 2'b00, 32'h0, 1'b0);
    set_s(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait s_htrans", o_htrans[0], 2);
      chk("wait s_haddr", o_haddr[0], 32'h400);
      chk("wait m0_hready", o_hready[0][0], 0);
      chk("wait s_hwdata", o_hwdata[0], 32'h44444444);
      step();
    end
    set_s(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("wait end m0_hready", o_hready[0][0], 1);
    step();

    // two-cycle ERROR on the m1 read
    set_s(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("err1 m1_hresp", o_hresp[0][1], 1);
    chk("err1 m1_hready", o_hready[0][1], 0);
    chk("err1 m0_hready", o_hready[0][0], 1);
    step();
    set_s(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("err2 m1_hresp", o_hresp[0][1], 1);
    chk("err2 m1_hready", o_hready[0][1], 1);
    chk("err2 m0_hresp", o_hresp[0][0], 0);
    step();
    set_s(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("err after m1_hready", o_hready[0][1], 1);
    chk("err after s_htrans", o_htrans[0], 0);

    // randomized traffic with wait states, errors and one mid-run reset
    for (int g = 0; g < 2; g++) begin
      dp[g] = 1'b0;
      err_2nd[g] = 1'b0;
    end
    was_rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        smp_ns[g] = (o_htrans[g] == 2'b10);
        for (int m = 0; m < 2; m++) smp_rdy[g][m] = o_hready[g][m];
      end
      @(posedge clk);
      #1;
      was_rst = rst;
      rst = (c == 1500);
      req_pct = (c < 1000) ? 50 : ((c < 2000) ? 95 : 70);
      for (int g = 0; g < 2; g++) begin
        if (was_rst || rst) begin
          dp[g] = 1'b0;
          err_2nd[g] = 1'b0;
        end else if (d_s_hready[g]) begin
          dp[g] = smp_ns[g];
        end
        if (err_2nd[g]) begin
          d_s_hready[g] = 1'b1;
          d_s_hresp[g]  = 1'b1;
          err_2nd[g]    = 1'b0;
        end else if (dp[g] && !rst) begin
          r = $urandom_range(0, 99);
          d_s_hready[g] = (r < 60);
          d_s_hresp[g]  = (r >= 85);
          err_2nd[g]    = (r >= 85);
        end else begin
          d_s_hready[g] = 1'b1;
          d_s_hresp[g]  = 1'b0;
        end
        d_s_hrdata[g] = $urandom;
        for (int m = 0; m < 2; m++) begin
          if (smp_rdy[g][m] || was_rst) begin
            if (d_htrans[g][m][1]) d_hwdata[g][m] = $urandom;
            r = $urandom_range(0, 99);
            d_htrans[g][m] = (r < req_pct) ? 2'b10 : ((r % 3 == 0) ? 2'b01 : 2'b00);
            d_haddr[g][m]  = $urandom;
            d_hwrite[g][m] = 1'($urandom_range(0, 1));
            d_hsize[g][m]  = 3'($urandom_range(0, 2));
            d_hprot[g][m]  = 4'($urandom_range(0, 15));
          end
        end
      end
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
